// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration channel between the board control master and clk_div_ctrl.
// Valid/ready offer of a new divisor, with done/err result pulses back to the master.
interface clk_div_ctrl_if #(
  parameter int P_CNT_W = 16
) ();
  logic [P_CNT_W-1:0] cfg_div;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_done;
  logic               cfg_err;

  modport master (
    output cfg_div, cfg_valid,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_div, cfg_valid,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with start/stop sequencing; divisor changes land only on
// full-period boundaries and stops always finish the high half, so no runt pulses appear.
//
// state        | meaning
// ST_IDLE      | output held low, counter cleared, waiting for i_en
// ST_RUN       | counting half periods and toggling o_clk_div
// ST_STOP_WAIT | i_en dropped while high; finish the high half then go idle
module clk_div_ctrl #(
  parameter int P_DEFAULT_DIV = 2,
  parameter int P_CNT_W       = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  clk_div_ctrl_if.slave  cfg,
  output logic           o_running,
  output logic           o_clk_div
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [P_CNT_W-1:0] div_q, div_d;
  logic [P_CNT_W-1:0] pend_div_q, pend_div_d;
  logic               pend_q, pend_d;
  logic               clk_div_q, clk_div_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               running_q, running_d;

  logic [P_CNT_W-1:0] half;
  logic               at_bnd;
  logic               xfer;
  logic               apply;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clk_div_d  = clk_div_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    apply      = 1'b0;

    half   = div_q >> 1;
    at_bnd = (cnt_q == half - P_CNT_W'(1));
    xfer   = cfg.cfg_valid && ready_q;

    case (state_q)
      ST_IDLE: begin
        clk_div_d = 1'b0;
        cnt_d     = '0;
        // a divisor accepted on the very edge we dropped into idle lands here
        apply     = pend_q;
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (at_bnd) begin
          cnt_d     = '0;
          clk_div_d = ~clk_div_q;
        end else begin
          cnt_d = cnt_q + P_CNT_W'(1);
        end
        if (!i_en && !clk_div_q) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          clk_div_d = 1'b0;
          apply     = pend_q;
        end else if (!i_en) begin
          if (at_bnd) begin
            state_d = ST_IDLE;
            apply   = pend_q;
          end else begin
            state_d = ST_STOP_WAIT;
          end
        end else if (at_bnd && clk_div_q) begin
          apply = pend_q;
        end
      end
      ST_STOP_WAIT: begin
        if (at_bnd) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          clk_div_d = 1'b0;
          apply     = pend_q;
        end else begin
          cnt_d = cnt_q + P_CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        clk_div_d = 1'b0;
      end
    endcase

    if (apply) begin
      div_d   = pend_div_q;
      pend_d  = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b1;
      cnt_d   = '0;
    end

    // xfer needs ready, which implies nothing pending, so it never collides with apply
    if (xfer) begin
      if (cfg.cfg_div < P_CNT_W'(2)) begin
        err_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
        div_d  = cfg.cfg_div;
        done_d = 1'b1;
      end else begin
        pend_div_d = cfg.cfg_div;
        pend_d     = 1'b1;
        ready_d    = 1'b0;
      end
    end

    running_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= P_CNT_W'(P_DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      clk_div_q  <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_div_q  <= clk_div_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      running_q  <= running_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign o_running     = running_q;
  assign o_clk_div     = clk_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: expected phase lengths are queued as stimulus is
// applied and popped against measured o_clk_div phases; handshake pulses checked inline.
module tb_clk_div_ctrl;
  localparam int P_CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic running;
  logic clk_div;

  clk_div_ctrl_if #(.P_CNT_W(P_CNT_W)) cfg_if ();

  clk_div_ctrl #(.P_DEFAULT_DIV(2), .P_CNT_W(P_CNT_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .cfg       (cfg_if.slave),
    .o_running (running),
    .o_clk_div (clk_div)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];

  always @(negedge clk) begin
    if (!rst && cfg_if.cfg_done) done_cnt++;
    if (!rst && cfg_if.cfg_err)  err_cnt++;
  end

  // length in samples of the current phase, starting from the present sample
  task automatic phase_len(output int n);
    logic lvl;
    lvl = clk_div;
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (clk_div !== lvl) return;
      n++;
    end
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (clk_div === lvl) return;
    end
    n = -1;
    n_cmp++; n_err++;
    $display("FAIL wait_level timeout: clk_div never reached %0b", lvl);
  endtask

  task automatic offer(input logic [P_CNT_W-1:0] d);
    cfg_if.cfg_div   = d;
    cfg_if.cfg_valid = 1'b1;
  endtask

  task automatic check_phases(input string name);
    int got, exp;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      phase_len(got);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s phase: got %0d expected %0d", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (clk_div !== 1'b0) begin n_err++; $display("FAIL reset clk_div: got %b expected 0", clk_div); end
    n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b expected 1", cfg_if.cfg_ready); end
    n_cmp++; if (cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", cfg_if.cfg_done); end
    n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL reset err: got %b expected 0", cfg_if.cfg_err); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset running: got %b expected 0", running); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_div2();
    int n;
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL div2 running: got %b expected 1", running); end
    wait_level(1'b1, n);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL div2 first high latency: got %0d expected 2", n + 1); end
    repeat (6) exp_q.push_back(1);
    check_phases("div2");
    en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (running !== 1'b0 || clk_div !== 1'b0) begin n_err++; $display("FAIL div2 stop: got running=%b clk_div=%b expected 0/0", running, clk_div); end
  endtask

  task automatic test_cfg_idle();
    int n, d0;
    d0 = done_cnt;
    offer(16'd10);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++; if (cfg_if.cfg_done !== 1'b1) begin n_err++; $display("FAIL idle cfg done: got %b expected 1", cfg_if.cfg_done); end
    n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL idle cfg ready: got %b expected 1", cfg_if.cfg_ready); end
    @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL idle cfg done count: got %0d expected 1", done_cnt - d0); end
    en = 1'b1;
    wait_level(1'b1, n);
    n_cmp++; if (n !== 6) begin n_err++; $display("FAIL div10 first high latency: got %0d expected 6", n); end
    repeat (4) exp_q.push_back(5);
    check_phases("div10");
  endtask

  task automatic test_reconfig_run();
    int d0;
    d0 = done_cnt;
    offer(16'd4);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL run cfg ready: got %b expected 0", cfg_if.cfg_ready); end
    exp_q.push_back(4);
    check_phases("div10 high tail");
    n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_done !== 1'b1) begin n_err++; $display("FAIL apply ready/done: got %b/%b expected 1/1", cfg_if.cfg_ready, cfg_if.cfg_done); end
    repeat (5) exp_q.push_back(2);
    check_phases("div4");
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL run cfg done count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_cfg_err();
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    offer(16'd1);
    @(negedge clk);
    n_cmp++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL err div1: got %b expected 1", cfg_if.cfg_err); end
    offer(16'd0);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++; if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL err div0 err/ready: got %b/%b expected 1/1", cfg_if.cfg_err, cfg_if.cfg_ready); end
    @(negedge clk);
    n_cmp++; if (err_cnt - e0 !== 2 || done_cnt - d0 !== 0) begin n_err++; $display("FAIL err counts: got err=%0d done=%0d expected 2/0", err_cnt - e0, done_cnt - d0); end
    wait_level(~clk_div, n);
    repeat (4) exp_q.push_back(2);
    check_phases("div4 after err");
  endtask

  task automatic test_stop();
    int n, highs;
    logic ok;
    en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (running === 1'b0) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stop timeout: running got %b expected 0", running); end
    offer(16'd8);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    en = 1'b1;
    wait_level(1'b1, n);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL div8 first high latency: got %0d expected 5", n); end
    en = 1'b0;
    exp_q.push_back(4);
    check_phases("stop in high");
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL stop high running: got %b expected 0", running); end
    highs = 0;
    repeat (12) begin
      @(negedge clk);
      if (clk_div !== 1'b0 || running !== 1'b0) highs++;
    end
    n_cmp++; if (highs !== 0) begin n_err++; $display("FAIL idle quiet: got %0d active samples expected 0", highs); end
    en = 1'b1;
    wait_level(1'b1, n);
    exp_q.push_back(4);
    check_phases("div8 high");
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (running !== 1'b0 || clk_div !== 1'b0) begin n_err++; $display("FAIL stop low: got running=%b clk_div=%b expected 0/0", running, clk_div); end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    en = 1'b1;
    wait_level(1'b1, n);
    offer(16'd6);
    en = 1'b0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++; if (cfg_if.cfg_ready !== 1'b0 || running !== 1'b1) begin n_err++; $display("FAIL stop_wait pending ready/running: got %b/%b expected 0/1", cfg_if.cfg_ready, running); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (clk_div !== 1'b0 || running !== 1'b0) begin n_err++; $display("FAIL async reset clk/running: got %b/%b expected 0/0", clk_div, running); end
    n_cmp++; if (cfg_if.cfg_ready !== 1'b1 || cfg_if.cfg_done !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL async reset ready/done/err: got %b/%b/%b expected 1/0/0", cfg_if.cfg_ready, cfg_if.cfg_done, cfg_if.cfg_err); end
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    en = 1'b1;
    wait_level(1'b1, n);
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL post-reset first high latency: got %0d expected 2", n); end
    repeat (4) exp_q.push_back(1);
    check_phases("post-reset div2");
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL post-reset done count: got %0d expected 0", done_cnt - d0); end
  endtask

  initial begin
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_valid = 1'b0;
    test_reset();
    test_default_div2();
    test_cfg_idle();
    test_reconfig_run();
    test_cfg_err();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time programmable clock divider controller with a start/stop sequencer and divisor reconfiguration that never produces runt pulses.
- Owns the divider counter and the divided-output register.
- Accepts new divide ratios from a control master over a valid/ready handshake.
- Applies a new ratio only on a full-period boundary and stops the output cleanly at a low level.
- Sits between the board control logic and the LED / low-rate timing blocks.

Parameters:
- P_DEFAULT_DIV, 2: divisor in force after reset; legal range 2..65535.
- P_CNT_W, 16: width of the divisor and of the half-period counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  1  run request; level-sensitive
- i_cfg_div  in  P_CNT_W  new divisor
- i_cfg_valid  in  1  divisor offer
- o_cfg_ready  out  1  controller can accept a divisor
- o_cfg_done  out  1  one-cycle pulse: a divisor became active
- o_cfg_err  out  1  one-cycle pulse: offered divisor rejected
- o_running  out  1  high in RUN or STOP_WAIT
- o_clk_div  out  1  divided clock, registered

Behaviour:
- Reset values (async on i_rst): o_clk_div=0, counter=0, active divisor=P_DEFAULT_DIV, pending empty, state IDLE, o_cfg_ready=1, o_cfg_done=0, o_cfg_err=0, o_running=0.
- Arithmetic:
  - half = active_div >> 1; odd divisors floor, so div 5 gives period 4.
  - The counter runs 0..half-1. On the edge where counter==half-1, the counter goes to 0 and o_clk_div toggles.
  - Output period is 2*half cycles at 50% duty.
- States: IDLE, RUN, STOP_WAIT.
- IDLE:
  - o_clk_div=0, counter held at 0.
  - If i_en=1, go to RUN on the next edge with counter=0.
  - First rising output edge occurs half+1 edges after i_en is first sampled high.
- RUN:
  - Counts as above.
  - If i_en=0 is sampled and o_clk_div=0, go to IDLE next edge with counter=0. The low half is truncated; this is allowed.
  - If i_en=0 is sampled and o_clk_div=1, go to STOP_WAIT.
- STOP_WAIT:
  - Keeps counting and completes the high half.
  - On the falling toggle, go to IDLE with o_clk_div=0.
  - i_en is ignored here; if i_en is high in IDLE, RUN restarts on the following edge.
- Config transfer occurs when i_cfg_valid && o_cfg_ready.
  - i_cfg_div<2: rejected. o_cfg_err=1 the next cycle, nothing is stored, o_cfg_ready stays 1.
  - Accepted in IDLE: the new divisor is active next edge and o_cfg_done pulses that same cycle.
  - Accepted in RUN or STOP_WAIT: the divisor is stored as pending and o_cfg_ready drops to 0 next cycle.
- Applying a pending divisor:
  - Applied on the falling-toggle edge, i.e. counter==half-1 with o_clk_div=1.
  - On that edge the active divisor is replaced and the counter is cleared; the next low half uses the new half.
  - Also applied on any transition into IDLE.
  - o_cfg_done pulses on the cycle after application; o_cfg_ready returns to 1 that same cycle.
- Only one divisor may be pending at a time; o_cfg_ready=0 enforces this.
- Simultaneous events:
  - Stop request plus boundary on the same edge: the divisor is applied and the state goes to IDLE.
  - A valid config on the same edge the pending one is applied is not accepted, because ready is still 0.
- Reset mid-operation: all state returns to reset values immediately; any pending divisor is discarded and no done or err pulse is generated.
- The counter never exceeds half-1; there is no wrap past 2^P_CNT_W.
- div=65535 gives half=32767 and period 65534.

Test Plan:
- Reset, then i_en=1 with default div 2 -> o_clk_div toggles every cycle (period 2); first high occurs 2 edges after i_en is sampled.
- In IDLE, offer div=10 -> o_cfg_done pulses next cycle; after i_en=1, output is 5 cycles high and 5 low repeatedly.
- Running at div=10, offer div=4 mid-high-phase -> o_cfg_ready=0 until the falling edge; the next low phase is 2 cycles; o_cfg_done pulses once; no phase shorter than 2 cycles appears.
- Offer div=1, then div=0 -> o_cfg_err pulses once for each; the active divisor and waveform are unchanged.
- Running at div=8, drop i_en during the high phase -> the high phase completes its full 4 cycles, then output stays 0 and o_running=0. Drop i_en during the low phase -> IDLE on the next edge.
- Assert i_rst during STOP_WAIT with a divisor pending -> all outputs go to reset values immediately; after release and i_en=1, period equals 2*(P_DEFAULT_DIV>>1) and no o_cfg_done pulse appears.
